// File: rtl/iram_dump_tx.sv
// iram_dump_tx: streams instruction RAM words out of a UART (8N1), three
// frames per 24-bit word, MSB byte first. Optional feature macro:
// DUMP_CHECKSUM_EN appends one frame carrying the mod-256 sum of all sent
// bytes before done. Assumes CLKS_PER_BIT >= 2.
module iram_dump_tx #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  word_count,
  output logic [7:0]  iram_addr,
  input  logic [23:0] iram_data,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = (CLKS_PER_BIT > 1) ? CW'(CLKS_PER_BIT - 2) : '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    START,
    DATA,
    STOP,
    NEXT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wc_q, wc_d;
  logic [23:0]   shift_q, shift_d;
  logic [7:0]    iram_addr_q, iram_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tx_q, tx_d;
  logic [7:0]    cur_byte;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
  logic          chk_q, chk_d;
`endif

  assign iram_addr = iram_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tx        = tx_q;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    wc_d        = wc_q;
    shift_d     = shift_q;
    iram_addr_d = iram_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    sum_d       = sum_q;
    chk_d       = chk_q;
`endif

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (word_count != 8'd0) begin
            state_d     = FETCH;
            addr_d      = '0;
            iram_addr_d = '0;
            wc_d        = word_count;
            busy_d      = 1'b1;
            baud_d      = '0;
`ifdef DUMP_CHECKSUM_EN
            sum_d       = '0;
            chk_d       = 1'b0;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end

      FETCH: begin
        state_d = LATCH;
      end

      LATCH: begin
        shift_d = iram_data;
        byte_d  = '0;
        baud_d  = '0;
        state_d = START;
`ifdef DUMP_CHECKSUM_EN
        sum_d   = sum_q + iram_data[23:16] + iram_data[15:8] + iram_data[7:0];
`endif
      end

      START: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      STOP: begin
        // The last stop bit of a word ends one cycle early: its final tx=1
        // cycle is spent in NEXT, keeping the inter-word gap at FETCH+LATCH.
        if (byte_q == 2'd2) begin
          if (baud_q == STOP_LAST) begin
            baud_d  = '0;
            state_d = NEXT;
          end else begin
            baud_d = baud_q + CW'(1);
          end
        end else if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          byte_d  = byte_q + 2'd1;
          shift_d = {shift_q[15:0], 8'h00};
          state_d = START;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      NEXT: begin
`ifdef DUMP_CHECKSUM_EN
        if (chk_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if ((addr_q + 8'd1) == wc_q) begin
          addr_d  = addr_q + 8'd1;
          chk_d   = 1'b1;
          shift_d = {sum_q, 16'h0000};
          byte_d  = 2'd2;
          baud_d  = '0;
          state_d = START;
        end else begin
          addr_d      = addr_q + 8'd1;
          iram_addr_d = addr_q + 8'd1;
          state_d     = FETCH;
        end
`else
        addr_d = addr_q + 8'd1;
        if ((addr_q + 8'd1) == wc_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          iram_addr_d = addr_q + 8'd1;
          state_d     = FETCH;
        end
`endif
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // tx follows the state being entered so the line is registered.
    cur_byte = shift_d[23:16];
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      addr_q      <= '0;
      wc_q        <= '0;
      shift_q     <= '0;
      iram_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tx_q        <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
      sum_q       <= '0;
      chk_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      wc_q        <= wc_d;
      shift_q     <= shift_d;
      iram_addr_q <= iram_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tx_q        <= tx_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q       <= sum_d;
      chk_q       <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_iram_dump_tx.sv
// Directed bench for iram_dump_tx at CLK_FREQ=16, BAUD=4 (4 clks per bit).
// Expected tx is rebuilt per dump from the bench's own RAM contents.
module tb_iram_dump_tx;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  word_count;
  logic [7:0]  iram_addr;
  logic [23:0] iram_data;
  logic        busy;
  logic        done;
  logic        tx;

  logic [23:0] ram [256];
  bit          exp_q [$];
  int          checks   = 0;
  int          failures = 0;
  int          done_cnt = 0;

  iram_dump_tx #(
    .CLK_FREQ(16),
    .BAUD    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .word_count(word_count),
    .iram_addr (iram_addr),
    .iram_data (iram_data),
    .busy      (busy),
    .done      (done),
    .tx        (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction RAM: data valid one clk after the address.
  always @(posedge clk) iram_data <= ram[iram_addr];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 4; i++) exp_q.push_back(b[k]);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
  endtask

  // Run one dump of n>0 words. If poke_at >= 0, a second start and a new
  // word_count are presented at that cycle and must be ignored.
  task automatic run_dump(input string name, input int n, input int poke_at);
    logic [7:0]  sum;
    logic [23:0] w;
    int tx_bad, busy_bad, done_bad, addr_bad, dc0;
    exp_q.delete();
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = ram[i];
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      push_frame(w[23:16]);
      push_frame(w[15:8]);
      push_frame(w[7:0]);
      sum = sum + w[23:16] + w[15:8] + w[7:0];
    end
`ifdef DUMP_CHECKSUM_EN
    push_frame(sum);
`endif
    tx_bad = -1; busy_bad = -1; done_bad = -1; addr_bad = -1;
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    word_count = 8'(n);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (tx !== exp_q[i] && tx_bad < 0) tx_bad = i;
      if (busy !== 1'b1 && busy_bad < 0) busy_bad = i;
      if (done !== 1'b0 && done_bad < 0) done_bad = i;
      if ((i % 122) == 0 && i / 122 < n && int'(iram_addr) != i / 122 && addr_bad < 0)
        addr_bad = i;
      if (i == poke_at) begin
        start = 1'b1;
        word_count = 8'd7;
      end
      if (i == poke_at + 1) start = 1'b0;
    end
    check({name, "_tx_first_bad_cycle"}, tx_bad, -1);
    check({name, "_busy_first_bad_cycle"}, busy_bad, -1);
    check({name, "_done_early_cycle"}, done_bad, -1);
    check({name, "_fetch_addr_bad_cycle"}, addr_bad, -1);
    @(negedge clk);
    check({name, "_done_pulse"}, int'(done), 1);
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_tx_after"}, int'(tx), 1);
    @(negedge clk);
    check({name, "_done_single"}, int'(done), 0);
    check({name, "_addr_hold"}, int'(iram_addr), n - 1);
    check({name, "_done_count"}, done_cnt - dc0, 1);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    word_count = 8'd0;
    for (int i = 0; i < 256; i++) ram[i] = 24'h000000;
    repeat (2) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(iram_addr), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single word A1 B2 C3.
    ram[0] = 24'hA1B2C3;
    run_dump("one_word", 1, -1);

    // Three words, inter-word gaps and address order.
    ram[0] = 24'h000001;
    ram[1] = 24'h800000;
    ram[2] = 24'hFFFFFF;
    run_dump("three_words", 3, -1);

    // word_count = 0: done next cycle, nothing sent.
    @(negedge clk);
    start = 1'b1;
    word_count = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("wc0_done", int'(done), 1);
    check("wc0_busy", int'(busy), 0);
    check("wc0_tx", int'(tx), 1);
    @(negedge clk);
    check("wc0_done_single", int'(done), 0);
    check("wc0_tx_idle", int'(tx), 1);
    check("wc0_busy_idle", int'(busy), 0);

    // Second start and new word_count mid-dump are ignored.
    ram[0] = 24'h5A3C0F;
    ram[1] = 24'h00FF81;
    run_dump("restart_ignored", 2, 60);

    // Reset during bit 0 (=0) of frame 2 of word 1 (0x800000).
    ram[0] = 24'h000001;
    ram[1] = 24'h800000;
    ram[2] = 24'hFFFFFF;
    @(negedge clk);
    start = 1'b1;
    word_count = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (169) @(negedge clk);
    check("pre_rst_tx", int'(tx), 0);
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_addr", int'(iram_addr), 1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_tx", int'(tx), 1);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_addr", int'(iram_addr), 0);
    repeat (2) @(negedge clk);
    check("held_rst_tx", int'(tx), 1);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle_tx", int'(tx), 1);
    check("post_rst_idle_busy", int'(busy), 0);
    ram[0] = 24'h123456;
    run_dump("after_reset", 1, -1);

    // Full-range dump: addresses 0..254.
    for (int i = 0; i < 256; i++) ram[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A};
    run_dump("wc255", 255, -1);

`ifdef DUMP_CHECKSUM_EN
    // Frames 01 02 FF then checksum 02.
    ram[0] = 24'h0102FF;
    run_dump("checksum", 1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
